// File: rtl/dh_pkg.sv
// Shared types and constants for the Diffie-Hellman key-exchange blocks.
package dh_pkg;

  localparam int unsigned KEY_W     = 8;
  localparam int unsigned MSG_W     = 64;
  localparam int unsigned PROD_W    = 2 * KEY_W;
  localparam int unsigned MSG_BYTES = MSG_W / 8;
  localparam int unsigned MIN_PRIME = 3;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form: feedback = s[7]^s[5]^s[4]^s[3]
  localparam logic [KEY_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GEN_B,
    S_POW_B,
    S_SEND,
    S_POW_KEY,
    S_WAIT_MSG,
    S_ENCRYPT
  } dh_state_t;

  // Keystream for the byte-wise cipher: byte i = (key + i) mod 256.
  function automatic logic [MSG_W-1:0] key_stream(input logic [KEY_W-1:0] k);
    logic [MSG_W-1:0] ks;
    ks = '0;
    for (int i = 0; i < int'(MSG_BYTES); i++) begin
      ks[i*8 +: 8] = k + KEY_W'(i);
    end
    return ks;
  endfunction

endpackage

// File: rtl/dh_modexp.sv
// Modular exponentiation x^exp mod m, right-to-left square-and-multiply.
// Ports: clk, rst_n (async active-low), start (1-cycle pulse), x, exp, m -> res, rdy.
// Start cycle loads operands, 8 iteration cycles follow, rdy pulses the cycle after.
module dh_modexp
  import dh_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] x,
  input  logic [KEY_W-1:0] exp,
  input  logic [KEY_W-1:0] m,
  output logic [KEY_W-1:0] res,
  output logic             rdy
);

  logic [KEY_W-1:0]  r_q, r_d, base_q, base_d, e_q, e_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              run_q, run_d, rdy_q, rdy_d;
  logic [PROD_W-1:0] prod_rb, prod_bb;

  // Next-state for one square-and-multiply step
  always_comb begin
    r_d     = r_q;
    base_d  = base_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    rdy_d   = 1'b0;
    prod_rb = PROD_W'(r_q) * PROD_W'(base_q);
    prod_bb = PROD_W'(base_q) * PROD_W'(base_q);
    if (start) begin
      r_d    = KEY_W'(1);
      base_d = x % m;
      e_d    = exp;
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      if (e_q[0]) r_d = KEY_W'(prod_rb % PROD_W'(m));
      base_d = KEY_W'(prod_bb % PROD_W'(m));
      e_d    = e_q >> 1;
      cnt_d  = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d = 1'b0;
        rdy_d = 1'b1;
      end
    end
  end

  // Operand and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      base_q <= '0;
      e_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      base_q <= base_d;
      e_q    <= e_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      rdy_q  <= rdy_d;
    end
  end

  assign res = r_q;
  assign rdy = rdy_q;

endmodule

// File: rtl/drone_terminal.sv
// Drone-side Diffie-Hellman peer: latches g/p/A, draws secret b, publishes
// B = g^b mod p, derives key = A^b mod p, then XOR-encrypts 64-bit messages.
// Ports: clk, rst_n (async active-low); cc_rdy, g_in, p_in, A_part_key from C&C;
//        msg_valid, msg from payload; B_part_key, rdy_drone, key_valid, c, c_valid, busy out.
// Build option: DRONE_FIXED_SECRET_EN uses FIXED_B as the secret instead of the LFSR.
module drone_terminal
  import dh_pkg::*;
#(
  parameter logic [KEY_W-1:0] LFSR_SEED = 8'hA5
`ifdef DRONE_FIXED_SECRET_EN
  ,
  parameter logic [KEY_W-1:0] FIXED_B = 8'd15
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cc_rdy,
  input  logic [KEY_W-1:0] g_in,
  input  logic [KEY_W-1:0] p_in,
  input  logic [KEY_W-1:0] A_part_key,
  input  logic             msg_valid,
  input  logic [MSG_W-1:0] msg,
  output logic [KEY_W-1:0] B_part_key,
  output logic             rdy_drone,
  output logic             key_valid,
  output logic [MSG_W-1:0] c,
  output logic             c_valid,
  output logic             busy
);

  dh_state_t        state_q, state_d;
  logic [KEY_W-1:0] lfsr_q, lfsr_d;
  logic [KEY_W-1:0] g_q, g_d, p_q, p_d, a_q, a_d, b_q, b_d, key_q, key_d;
  logic [KEY_W-1:0] bpk_q, bpk_d;
  logic             rdy_drone_q, rdy_drone_d, key_valid_q, key_valid_d;
  logic [MSG_W-1:0] c_q, c_d;
  logic             c_valid_q, c_valid_d, busy_q, busy_d;
  logic             mx_started_q, mx_started_d;
  logic             mx_start_c, mx_rdy;
  logic [KEY_W-1:0] mx_x_c, mx_res;
  logic             lfsr_fb;

  // Shared exponentiator: base g for B, base A for the key
  assign mx_x_c = (state_q == S_POW_KEY) ? a_q : g_q;

  dh_modexp u_modexp (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mx_start_c),
    .x     (mx_x_c),
    .exp   (b_q),
    .m     (p_q),
    .res   (mx_res),
    .rdy   (mx_rdy)
  );

  assign lfsr_fb = ^(lfsr_q & LFSR_TAPS);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    g_d          = g_q;
    p_d          = p_q;
    a_d          = a_q;
    b_d          = b_q;
    key_d        = key_q;
    bpk_d        = bpk_q;
    rdy_drone_d  = rdy_drone_q;
    key_valid_d  = key_valid_q;
    c_d          = c_q;
    c_valid_d    = 1'b0;
    mx_started_d = mx_started_q;
    mx_start_c   = 1'b0;

    // One start pulse on entry to each exponentiation state
    if ((state_q == S_POW_B || state_q == S_POW_KEY) && !mx_started_q) begin
      mx_start_c   = 1'b1;
      mx_started_d = 1'b1;
    end else if (mx_rdy) begin
      mx_started_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cc_rdy && (p_in >= KEY_W'(MIN_PRIME))) state_d = S_LOAD;
      end
      S_LOAD: begin
        g_d     = g_in;
        p_d     = p_in;
        a_d     = A_part_key;
        state_d = S_GEN_B;
      end
      S_GEN_B: begin
`ifdef DRONE_FIXED_SECRET_EN
        b_d = FIXED_B;
`else
        // Exponents 0 and 1 would leak g or 1; substitute 2
        b_d = (lfsr_q <= KEY_W'(1)) ? KEY_W'(2) : lfsr_q;
`endif
        lfsr_d  = {lfsr_q[KEY_W-2:0], lfsr_fb};
        state_d = S_POW_B;
      end
      S_POW_B: begin
        if (mx_rdy) begin
          bpk_d   = mx_res;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        rdy_drone_d = 1'b1;
        state_d     = S_POW_KEY;
      end
      S_POW_KEY: begin
        if (mx_rdy) begin
          key_d       = mx_res;
          key_valid_d = 1'b1;
          state_d     = S_WAIT_MSG;
        end
      end
      S_WAIT_MSG: begin
        // Ciphertext is produced on entry so c_valid covers the ENCRYPT cycle
        if (msg_valid) begin
          c_d       = msg ^ key_stream(key_q);
          c_valid_d = 1'b1;
          state_d   = S_ENCRYPT;
        end
      end
      S_ENCRYPT: state_d = S_WAIT_MSG;
      default:   state_d = S_IDLE;
    endcase

    busy_d = !(state_d == S_IDLE || state_d == S_WAIT_MSG);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      g_q          <= '0;
      p_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      key_q        <= '0;
      bpk_q        <= '0;
      rdy_drone_q  <= 1'b0;
      key_valid_q  <= 1'b0;
      c_q          <= '0;
      c_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      mx_started_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      g_q          <= g_d;
      p_q          <= p_d;
      a_q          <= a_d;
      b_q          <= b_d;
      key_q        <= key_d;
      bpk_q        <= bpk_d;
      rdy_drone_q  <= rdy_drone_d;
      key_valid_q  <= key_valid_d;
      c_q          <= c_d;
      c_valid_q    <= c_valid_d;
      busy_q       <= busy_d;
      mx_started_q <= mx_started_d;
    end
  end

  assign B_part_key = bpk_q;
  assign rdy_drone  = rdy_drone_q;
  assign key_valid  = key_valid_q;
  assign c          = c_q;
  assign c_valid    = c_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_drone_terminal.sv
// Scoreboard bench for drone_terminal: stimulus pushes expected B / ciphertext
// events into a queue; a negedge monitor pops and compares on rdy_drone rise / c_valid.
module tb_drone_terminal;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cc_rdy;
  logic [7:0]  g_in, p_in, A_part_key;
  logic        msg_valid;
  logic [63:0] msg;
  logic [7:0]  B_part_key;
  logic        rdy_drone, key_valid;
  logic [63:0] c;
  logic        c_valid, busy;

`ifdef DRONE_FIXED_SECRET_EN
  // b = 15: B = 5^15 mod 23 = 19, key = 8^15 mod 23 = 2
  localparam logic [7:0]  EXP_B  = 8'd19;
  localparam logic [63:0] EXP_C0 = 64'h0908070605040302;
  localparam logic [63:0] EXP_CF = 64'hF6F7F8F9FAFBFCFD;
  localparam logic [63:0] EXP_C1 = 64'h082B42618CAFCEED;
`else
  // b = seed 0xA5 = 165: B = 5^165 mod 23 = 22, key = 8^165 mod 23 = 1
  localparam logic [7:0]  EXP_B  = 8'd22;
  localparam logic [63:0] EXP_C0 = 64'h0807060504030201;
  localparam logic [63:0] EXP_CF = 64'hF7F8F9FAFBFCFDFE;
  localparam logic [63:0] EXP_C1 = 64'h092443628DA8CFEE;
`endif
  localparam logic [63:0] MSG_1  = 64'h0123456789ABCDEF;

  typedef struct {
    bit          is_c;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_rdy = 1'b0;
  logic prev_cv  = 1'b0;

  drone_terminal dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cc_rdy     (cc_rdy),
    .g_in       (g_in),
    .p_in       (p_in),
    .A_part_key (A_part_key),
    .msg_valid  (msg_valid),
    .msg        (msg),
    .B_part_key (B_part_key),
    .rdy_drone  (rdy_drone),
    .key_valid  (key_valid),
    .c          (c),
    .c_valid    (c_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares DUT output events against the scoreboard
  always @(negedge clk) begin
    if (rdy_drone && !prev_rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected: rdy_drone rose with nothing expected (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("b_kind", 64'(mon_e.is_c), 64'(0));
        check("b_part_key", 64'(B_part_key), mon_e.data);
        check("rdy_latency_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    if (c_valid) begin
      check("c_valid_pulse", 64'(prev_cv), 64'(0));
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL c_unexpected: c_valid with c=%h, nothing expected (cycle %0d)", c, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("c_kind", 64'(mon_e.is_c), 64'(1));
        check("c_data", c, mon_e.data);
      end
    end
    prev_rdy <= rdy_drone;
    prev_cv  <= c_valid;
  end

  task automatic push_b();
    exp_t e;
    e.is_c = 1'b0;
    e.data = 64'(EXP_B);
    e.cyc  = cyc + 14;  // sampled next edge, then 13 cycles
    sb.push_back(e);
  endtask

  task automatic push_c(input logic [63:0] d);
    exp_t e;
    e.is_c = 1'b1;
    e.data = d;
    e.cyc  = -1;
    sb.push_back(e);
  endtask

  // g=5, p=23, A=8; cc_rdy dropped and inputs scrambled after LOAD
  task automatic start_session();
    g_in = 8'd5; p_in = 8'd23; A_part_key = 8'd8; cc_rdy = 1'b1;
    push_b();
    tick(2);
    cc_rdy = 1'b0; g_in = 8'd7; p_in = 8'd2; A_part_key = 8'd99;
  endtask

  task automatic wait_rdy();
    int t = 0;
    while (!rdy_drone && t < 40) begin tick(1); t++; end
    check("rdy_drone_timeout", 64'(rdy_drone), 64'(1));
  endtask

  task automatic wait_key();
    int t = 0;
    while (!key_valid && t < 40) begin tick(1); t++; end
    check("key_valid_timeout", 64'(key_valid), 64'(1));
  endtask

  task automatic send_msg(input logic [63:0] m, input logic [63:0] exp_c);
    msg = m; msg_valid = 1'b1;
    push_c(exp_c);
    tick(1);
    msg_valid = 1'b0;
    tick(3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_B"}, 64'(B_part_key), 64'(0));
    check({tag, "_rdy_drone"}, 64'(rdy_drone), 64'(0));
    check({tag, "_key_valid"}, 64'(key_valid), 64'(0));
    check({tag, "_c"}, c, 64'(0));
    check({tag, "_c_valid"}, 64'(c_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_busy, saw_rdy;
    rst_n = 1'b0; cc_rdy = 1'b0; g_in = '0; p_in = '0; A_part_key = '0;
    msg_valid = 1'b0; msg = '0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // p < 3 is rejected: stays idle for 50 cycles
    g_in = 8'd5; p_in = 8'd2; A_part_key = 8'd8; cc_rdy = 1'b1;
    saw_busy = 0; saw_rdy = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (busy) saw_busy = 1;
      if (rdy_drone) saw_rdy = 1;
    end
    check("small_p_busy", 64'(saw_busy), 64'(0));
    check("small_p_rdy_drone", 64'(saw_rdy), 64'(0));
    cc_rdy = 1'b0;
    tick(2);

    // Full session
    start_session();
    tick(3);
    check("busy_during_pow_b", 64'(busy), 64'(1));
    wait_rdy();
    wait_key();
    tick(1);
    check("busy_wait_msg", 64'(busy), 64'(0));

    send_msg(64'h0, EXP_C0);

    // Back-to-back: second pulse lands during ENCRYPT and is dropped
    msg = 64'hFFFF_FFFF_FFFF_FFFF; msg_valid = 1'b1;
    push_c(EXP_CF);
    tick(1);
    msg = 64'hDEAD_BEEF_0000_1111;
    tick(1);
    msg_valid = 1'b0;
    tick(3);
    check("c_hold", c, EXP_CF);

    send_msg(MSG_1, EXP_C1);
    check("c_hold_after_c1", c, EXP_C1);

    // Reset while POW_KEY runs
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
    start_session();
    wait_rdy();
    tick(3);
    check("busy_pow_key", 64'(busy), 64'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick(2);
    rst_n = 1'b1;
    tick(1);

    start_session();
    wait_rdy();
    wait_key();
    tick(1);
    send_msg(MSG_1, EXP_C1);

    tick(5);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
